// File: rtl/mips_mc_ctrl_param_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
// With MC_CTRL_ILLEGAL_EN defined the bundle also carries illegal_op.
interface mips_mc_ctrl_param_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       irwrite;
  logic       memwrite;
  logic       iord;
  logic       pcen;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [1:0] alusrcb;
  logic       alusrca;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       bne_sign;
  logic       zeroext;
  logic       instr_done;
  logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_EN
  logic       illegal_op;
`endif

  modport master (
`ifdef MC_CTRL_ILLEGAL_EN
    output illegal_op,
`endif
    input  op, funct, zero,
    output irwrite, memwrite, iord, pcen, pcsrc, alucontrol, alusrcb, alusrca,
    output regwrite, regdst, memtoreg, bne_sign, zeroext, instr_done, state
  );

  modport slave (
`ifdef MC_CTRL_ILLEGAL_EN
    input  illegal_op,
`endif
    output op, funct, zero,
    input  irwrite, memwrite, iord, pcen, pcsrc, alucontrol, alusrcb, alusrca,
    input  regwrite, regdst, memtoreg, bne_sign, zeroext, instr_done, state
  );
endinterface

// File: rtl/mips_mc_ctrl_param.sv
// Multicycle MIPS main FSM + ALU decoder with a fixed MEM_LAT-cycle memory wait.
// Macro MC_CTRL_ILLEGAL_EN: undecoded op/funct traps in ILLEGAL and raises illegal_op.
module mips_mc_ctrl_param #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_ctrl_param_if.master bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || (2 ** CNT_W) <= MEM_LAT) begin : g_param_chk
    $error("mips_mc_ctrl_param: MEM_LAT must be 1..15 and fit in CNT_W bits");
  end

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_IEX     = 4'd10,
    S_IWB     = 4'd11,
    S_JEX     = 4'd12
`ifdef MC_CTRL_ILLEGAL_EN
    , S_ILLEGAL = 4'd13
`endif
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             last_c;

  logic       rtype_known_c, imm_zext_c;
  logic [2:0] rtype_alu_c, imm_alu_c;

  logic       irwrite_c, memwrite_c, iord_c, pcen_c, alusrca_c;
  logic       regwrite_c, regdst_c, memtoreg_c, bne_sign_c, zeroext_c;
  logic       instr_done_c, illegal_c;
  logic [1:0] pcsrc_c, alusrcb_c;
  logic [2:0] alucontrol_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign last_c = (wait_cnt_q == CNT_LAST);

  // ALU decode for R-type funct and for I-type op (IR is stable, so op is used live)
  always_comb begin
    rtype_known_c = 1'b1;
    case (bus.funct)
      6'b100000: rtype_alu_c = ALU_ADD;
      6'b100010: rtype_alu_c = ALU_SUB;
      6'b100100: rtype_alu_c = ALU_AND;
      6'b100101: rtype_alu_c = ALU_OR;
      6'b101010: rtype_alu_c = ALU_SLT;
      default: begin
        rtype_alu_c   = ALU_ADD;
        rtype_known_c = 1'b0;
      end
    endcase
    imm_zext_c = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
    case (bus.op)
      OP_ANDI: imm_alu_c = ALU_AND;
      OP_ORI:  imm_alu_c = ALU_OR;
      OP_SLTI: imm_alu_c = ALU_SLT;
      default: imm_alu_c = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d      = S_FETCH;
    wait_cnt_d   = '0;
    irwrite_c    = 1'b0;
    memwrite_c   = 1'b0;
    iord_c       = 1'b0;
    pcen_c       = 1'b0;
    pcsrc_c      = 2'b00;
    alucontrol_c = 3'b000;
    alusrcb_c    = 2'b00;
    alusrca_c    = 1'b0;
    regwrite_c   = 1'b0;
    regdst_c     = 1'b0;
    memtoreg_c   = 1'b0;
    bne_sign_c   = 1'b0;
    zeroext_c    = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_c    = 2'b01;
        alucontrol_c = ALU_ADD;
        if (last_c) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          state_d   = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb_c    = 2'b11;
        alucontrol_c = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_R:                              state_d = S_RTYPEEX;
          OP_BEQ:                            state_d = S_BEQEX;
          OP_BNE:                            state_d = S_BNEEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEX;
          OP_J:                              state_d = S_JEX;
`ifdef MC_CTRL_ILLEGAL_EN
          default:                           state_d = S_ILLEGAL;
`else
          default:                           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_ADD;
        state_d      = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
        if (last_c) begin
          state_d = S_MEMWB;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          state_d    = S_MEMRD;
        end
      end
      S_MEMWB: begin
        regwrite_c   = 1'b1;
        memtoreg_c   = 1'b1;
        instr_done_c = 1'b1;
      end
      S_MEMWR: begin
        iord_c = 1'b1;
        if (last_c) begin
          memwrite_c   = 1'b1;
          instr_done_c = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          state_d    = S_MEMWR;
        end
      end
      S_RTYPEEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = rtype_alu_c;
        state_d      = S_RTYPEWB;
`ifdef MC_CTRL_ILLEGAL_EN
        if (!rtype_known_c) state_d = S_ILLEGAL;
`endif
      end
      S_RTYPEWB: begin
        regwrite_c   = 1'b1;
        regdst_c     = 1'b1;
        instr_done_c = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = 2'b01;
        bne_sign_c   = (state_q == S_BNEEX);
        pcen_c       = (state_q == S_BNEEX) ? ~bus.zero : bus.zero;
        instr_done_c = 1'b1;
      end
      S_IEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = imm_alu_c;
        zeroext_c    = imm_zext_c;
        state_d      = S_IWB;
      end
      S_IWB: begin
        regwrite_c   = 1'b1;
        alucontrol_c = imm_alu_c;
        zeroext_c    = imm_zext_c;
        instr_done_c = 1'b1;
      end
      S_JEX: begin
        pcsrc_c      = 2'b10;
        pcen_c       = 1'b1;
        instr_done_c = 1'b1;
      end
`ifdef MC_CTRL_ILLEGAL_EN
      S_ILLEGAL: begin
        illegal_c = 1'b1;
        state_d   = S_ILLEGAL;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is asserted so an aborted access never writes
  assign bus.irwrite    = irwrite_c & reset;
  assign bus.memwrite   = memwrite_c & reset;
  assign bus.pcen       = pcen_c & reset;
  assign bus.regwrite   = regwrite_c & reset;
  assign bus.instr_done = instr_done_c & reset;
  assign bus.iord       = iord_c;
  assign bus.pcsrc      = pcsrc_c;
  assign bus.alucontrol = alucontrol_c;
  assign bus.alusrcb    = alusrcb_c;
  assign bus.alusrca    = alusrca_c;
  assign bus.regdst     = regdst_c;
  assign bus.memtoreg   = memtoreg_c;
  assign bus.bne_sign   = bne_sign_c;
  assign bus.zeroext    = zeroext_c;
  assign bus.state      = state_q;
`ifdef MC_CTRL_ILLEGAL_EN
  assign bus.illegal_op = illegal_c;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl_param.sv
// Bench: two controllers (MEM_LAT=1 and 3) run random instruction streams against
// an instruction-level expected-cycle model, plus a reset abort during a store.
`timescale 1ns/1ps
module tb_mips_mc_ctrl_param;

  typedef struct packed {
    logic [3:0] state;
    logic       irwrite, memwrite, iord, pcen;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [1:0] alusrcb;
    logic       alusrca, regwrite, regdst, memtoreg, bne_sign, zeroext, instr_done, illegal_op;
  } out_t;

  typedef struct {
    out_t o;
    int   wk;
  } rec_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam int NR = 60;
`ifdef MC_CTRL_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] op_s    [2];
  logic [5:0] funct_s [2];
  logic       zero_s  [2];
  out_t       act     [2];

  mips_mc_ctrl_param_if if0 ();
  mips_mc_ctrl_param_if if1 ();

  assign if0.op = op_s[0];
  assign if0.funct = funct_s[0];
  assign if0.zero = zero_s[0];
  assign if1.op = op_s[1];
  assign if1.funct = funct_s[1];
  assign if1.zero = zero_s[1];

`ifdef MC_CTRL_ILLEGAL_EN
  assign act[0] = {if0.state, if0.irwrite, if0.memwrite, if0.iord, if0.pcen, if0.pcsrc, if0.alucontrol,
                   if0.alusrcb, if0.alusrca, if0.regwrite, if0.regdst, if0.memtoreg, if0.bne_sign,
                   if0.zeroext, if0.instr_done, if0.illegal_op};
  assign act[1] = {if1.state, if1.irwrite, if1.memwrite, if1.iord, if1.pcen, if1.pcsrc, if1.alucontrol,
                   if1.alusrcb, if1.alusrca, if1.regwrite, if1.regdst, if1.memtoreg, if1.bne_sign,
                   if1.zeroext, if1.instr_done, if1.illegal_op};
`else
  assign act[0] = {if0.state, if0.irwrite, if0.memwrite, if0.iord, if0.pcen, if0.pcsrc, if0.alucontrol,
                   if0.alusrcb, if0.alusrca, if0.regwrite, if0.regdst, if0.memtoreg, if0.bne_sign,
                   if0.zeroext, if0.instr_done, 1'b0};
  assign act[1] = {if1.state, if1.irwrite, if1.memwrite, if1.iord, if1.pcen, if1.pcsrc, if1.alucontrol,
                   if1.alusrcb, if1.alusrca, if1.regwrite, if1.regdst, if1.memtoreg, if1.bne_sign,
                   if1.zeroext, if1.instr_done, 1'b0};
`endif

  mips_mc_ctrl_param #(.MEM_LAT(1), .CNT_W(4)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  mips_mc_ctrl_param #(.MEM_LAT(3), .CNT_W(4)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t exp_q [2][$];
  int   icnt [2] = '{0, 0};
  int   post_idx [2] = '{0, 0};
  bit   gen_done [2] = '{1'b0, 1'b0};
  int   phase = 0;
  bit   armed = 1'b0;

  logic [5:0] d_op [5] = '{OP_LW, OP_BNE, OP_BNE, OP_ANDI, OP_R};
  logic [5:0] d_fn [5] = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b101010};
  logic       d_z  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [5:0] legal_ops [10] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J};
  logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // {known, alucontrol} for an R-type funct
  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(logic [5:0] o);
    case (o)
      OP_ANDI: return 3'b000;
      OP_ORI:  return 3'b001;
      OP_SLTI: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic pushr(int i, out_t o, int wk);
    rec_t r;
    r.o  = o;
    r.wk = wk;
    exp_q[i].push_back(r);
  endtask

  task automatic push_illegal(int i);
    out_t r;
    for (int k = 0; k < 3; k++) begin
      r = '0; r.state = 4'd13; r.illegal_op = 1'b1;
      pushr(i, r, k);
    end
  endtask

  // Expected per-cycle outputs of one whole instruction
  task automatic push_instr(int i, logic [5:0] o, logic [5:0] f, logic z);
    int L;
    out_t r;
    logic [3:0] ra;
    L = lat_of(i);
    for (int k = 0; k < L; k++) begin
      r = '0; r.alusrcb = 2'b01; r.alucontrol = 3'b010;
      r.irwrite = (k == L - 1); r.pcen = (k == L - 1);
      pushr(i, r, k);
    end
    r = '0; r.state = 4'd1; r.alusrcb = 2'b11; r.alucontrol = 3'b010;
    pushr(i, r, 0);
    case (o)
      OP_LW, OP_SW: begin
        r = '0; r.state = 4'd2; r.alusrca = 1'b1; r.alusrcb = 2'b10; r.alucontrol = 3'b010;
        pushr(i, r, 0);
        for (int k = 0; k < L; k++) begin
          r = '0; r.iord = 1'b1;
          if (o == OP_LW) r.state = 4'd3;
          else begin
            r.state = 4'd5; r.memwrite = (k == L - 1); r.instr_done = (k == L - 1);
          end
          pushr(i, r, k);
        end
        if (o == OP_LW) begin
          r = '0; r.state = 4'd4; r.regwrite = 1'b1; r.memtoreg = 1'b1; r.instr_done = 1'b1;
          pushr(i, r, 0);
        end
      end
      OP_R: begin
        ra = r_alu(f);
        r = '0; r.state = 4'd6; r.alusrca = 1'b1; r.alucontrol = ra[2:0];
        pushr(i, r, 0);
`ifdef MC_CTRL_ILLEGAL_EN
        if (!ra[3]) begin
          push_illegal(i);
          return;
        end
`endif
        r = '0; r.state = 4'd7; r.regwrite = 1'b1; r.regdst = 1'b1; r.instr_done = 1'b1;
        pushr(i, r, 0);
      end
      OP_BEQ, OP_BNE: begin
        r = '0; r.state = (o == OP_BEQ) ? 4'd8 : 4'd9; r.alusrca = 1'b1; r.alucontrol = 3'b110;
        r.pcsrc = 2'b01; r.pcen = (o == OP_BEQ) ? z : ~z; r.bne_sign = (o == OP_BNE);
        r.instr_done = 1'b1;
        pushr(i, r, 0);
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        r = '0; r.state = 4'd10; r.alusrca = 1'b1; r.alusrcb = 2'b10; r.alucontrol = i_alu(o);
        r.zeroext = (o == OP_ANDI) || (o == OP_ORI);
        pushr(i, r, 0);
        r = '0; r.state = 4'd11; r.regwrite = 1'b1; r.alucontrol = i_alu(o);
        r.zeroext = (o == OP_ANDI) || (o == OP_ORI); r.instr_done = 1'b1;
        pushr(i, r, 0);
      end
      OP_J: begin
        r = '0; r.state = 4'd12; r.pcsrc = 2'b10; r.pcen = 1'b1; r.instr_done = 1'b1;
        pushr(i, r, 0);
      end
      default: begin
`ifdef MC_CTRL_ILLEGAL_EN
        push_illegal(i);
`endif
      end
    endcase
  endtask

  task automatic rand_instr(output logic [5:0] o, output logic [5:0] f);
    o = legal_ops[$urandom_range(0, 9)];
    f = legal_fns[$urandom_range(0, 4)];
    if (!ILL) begin
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      if ($urandom_range(0, 5) == 0) f = 6'($urandom);
    end
  endtask

  task automatic gen_next(int i);
    logic [5:0] o, f;
    logic z;
    z = 1'($urandom_range(0, 1));
    f = 6'b100000;
    if (phase == 0) begin
      if (icnt[i] < 5) begin
        o = d_op[icnt[i]]; f = d_fn[icnt[i]]; z = d_z[icnt[i]];
      end else if (i == 1 && icnt[i] >= 5 + NR) begin
        o = OP_SW; armed = 1'b1;
      end else begin
        rand_instr(o, f);
      end
      icnt[i]++;
    end else begin
      if (post_idx[i] == 0) o = 6'b111111;
      else if (post_idx[i] == 1 && !ILL) o = OP_LW;
      else begin
        gen_done[i] = 1'b1;
        return;
      end
      post_idx[i]++;
    end
    op_s[i] = o; funct_s[i] = f; zero_s[i] = z;
    push_instr(i, o, f, z);
  endtask

  initial begin
    out_t  rst_rec;
    rec_t  e;
    int    cyc, rc, rst_hold;
    bit    hit_abort, done_all, seen1;
    logic [23:0] obs0;
    logic [2:0]  irw1;

    rst_rec = '0; rst_rec.alusrcb = 2'b01; rst_rec.alucontrol = 3'b010;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_s[i] = 6'd0; funct_s[i] = 6'd0; zero_s[i] = 1'b0;
    end
    cyc = 0; rc = 0; rst_hold = 2; done_all = 1'b0; seen1 = 1'b0;
    obs0 = '0; irw1 = '0;

    while (!done_all && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        #1;
        for (int i = 0; i < 2; i++)
          check($sformatf("reset inst%0d c%0d", i, cyc), 32'(act[i]), 32'(rst_rec));
        rst_hold--;
        if (rst_hold == 0) begin
          @(posedge clk);
          #2 reset = 1'b1;
          rc = 0;
        end
        continue;
      end
      rc++;
      for (int i = 0; i < 2; i++)
        if (exp_q[i].size() == 0 && !gen_done[i]) gen_next(i);
      #1;
      hit_abort = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          check($sformatf("inst%0d c%0d st%0d", i, cyc, e.o.state), 32'(act[i]), 32'(e.o));
          if (i == 1 && e.o.state == 4'd5 && e.wk == 1) hit_abort = 1'b1;
        end
      end
      // Hand-computed pins for the first lw on each controller
      if (phase == 0) begin
        if (rc <= 6) obs0 = {obs0[19:0], act[0].state};
        if (rc == 6) check("lat1 lw state sequence", 32'(obs0), 32'h000012340);
        if (rc == 5) check("lat1 lw wb strobes", 32'({act[0].regwrite, act[0].memtoreg, act[0].instr_done}), 32'h7);
        if (rc <= 3) irw1 = {irw1[1:0], act[1].irwrite};
        if (rc == 3) check("lat3 fetch irwrite", 32'(irw1), 32'h1);
        if (act[1].instr_done && !seen1) begin
          seen1 = 1'b1;
          check("lat3 lw cycles", 32'(rc), 32'd9);
        end
      end
      if (phase == 0 && armed && hit_abort) begin
        #1 reset = 1'b0;
        #1;
        check("abort state", 32'({act[0].state, act[1].state}), 32'h0);
        check("abort memwrite", 32'({act[0].memwrite, act[1].memwrite}), 32'h0);
        for (int i = 0; i < 2; i++) exp_q[i].delete();
        phase = 1;
        rst_hold = 2;
      end
      done_all = (phase == 1) && gen_done[0] && gen_done[1] &&
                 (exp_q[0].size() == 0) && (exp_q[1].size() == 0);
    end
    if (!done_all) check("run completion", 32'(cyc), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
